ex_mem_stage: RTL and testbench

EX/MEM boundary stage of the MIPS pipeline, directly downstream of the ALU. It registers the ALU result and control into the MEM stage and owns the architectural HI/LO registers written by mult/div. It models multi-cycle mult/div latency by stalling upstream, and resolves beq/bne into a registered branch-taken/flush pulse.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/muldiv_timer.sv | 64 ++++++
 rtl/ex_mem_stage.sv | 118 +++++++++++
 tb/tb_ex_mem_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU op codes and the mult/div timer state type.
package mips_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_DIV = 4'b0111;
  localparam logic [3:0] ALU_BEQ = 4'b1000;
  localparam logic [3:0] ALU_BNE = 4'b1001;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/muldiv_timer.sv
// Mult/div occupancy timer: holds EX for LAT unstalled cycles, flags the final one.
module muldiv_timer
  import mips_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  input  logic [CNT_W-1:0] lat,
  output logic             busy_stall,
  output logic             done
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             last;

  assign last = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The first occupancy cycle is spent in IDLE; BUSY counts the remaining LAT-1.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    busy_stall = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (lat > CNT_W'(1)) begin
            busy_stall = 1'b1;
            if (!hold) begin
              state_nx = ST_BUSY;
              cnt_nx   = lat - CNT_W'(1);
            end
          end else begin
            done = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (last) done = 1'b1;
        else      busy_stall = 1'b1;
        if (!hold) begin
          cnt_nx = cnt - CNT_W'(1);
          if (last) state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with HI/LO ownership and branch resolution.
// EXMEM_MULDIV_STALL_EN enables multi-cycle mult/div stalling; otherwise they complete in one cycle.
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*DATA_W-1:0]   alu_out,
  input  logic                  alu_zero,
  input  logic [3:0]            alu_op,
  input  logic                  ex_valid,
  input  logic                  ex_div_by_zero,
  input  logic [DATA_W-1:0]     ex_rt_data,
  input  logic [4:0]            ex_wreg,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic                  ex_memwrite,
  input  logic                  ex_branch,
  input  logic                  ex_mfhi,
  input  logic                  ex_mflo,
  input  logic [DATA_W-1:0]     ex_branch_target,
  input  logic                  mem_stall,
  output logic                  ex_stall,
  output logic                  mem_valid,
  output logic                  mem_regwrite,
  output logic                  mem_memread,
  output logic                  mem_memwrite,
  output logic [DATA_W-1:0]     mem_result,
  output logic [DATA_W-1:0]     mem_store_data,
  output logic [4:0]            mem_wreg,
  output logic                  br_taken,
  output logic [DATA_W-1:0]     br_target,
  output logic                  flush,
  output logic [DATA_W-1:0]     hi_q,
  output logic [DATA_W-1:0]     lo_q
);

  localparam int MAX_LAT = max_int(MUL_LAT, DIV_LAT);
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic              is_div, muldiv_op, br_op, keep, muldiv_go;
  logic              busy_stall, done, advance, hilo_we;
  logic [CNT_W-1:0]  lat;
  logic [DATA_W-1:0] result;

  assign flush     = br_taken & ~mem_stall;
  assign is_div    = (alu_op == ALU_DIV);
  assign muldiv_op = (alu_op == ALU_MUL) | is_div;
  assign br_op     = (alu_op == ALU_BEQ) | (alu_op == ALU_BNE);
  // A flushed slot must neither write state nor launch a mult/div.
  assign keep      = ex_valid & ~flush;
  assign muldiv_go = keep & muldiv_op;
  assign lat       = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

`ifdef EXMEM_MULDIV_STALL_EN
  muldiv_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .start      (muldiv_go),
    .hold       (mem_stall),
    .lat        (lat),
    .busy_stall (busy_stall),
    .done       (done)
  );
`else
  logic [CNT_W-1:0] unused_lat;
  assign unused_lat = lat;
  assign busy_stall = 1'b0;
  assign done       = 1'b1;
`endif

  assign ex_stall = mem_stall | busy_stall;
  assign advance  = ~ex_stall;
  assign hilo_we  = advance & muldiv_go & done & ~(is_div & ex_div_by_zero);

  always_comb begin
    result = alu_out[DATA_W-1:0];
    if (ex_mfhi)      result = hi_q;
    else if (ex_mflo) result = lo_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_regwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_wreg       <= '0;
      br_taken       <= 1'b0;
      br_target      <= '0;
      hi_q           <= '0;
      lo_q           <= '0;
    end else begin
      if (advance) begin
        mem_valid      <= keep;
        mem_regwrite   <= keep & ex_regwrite & ~muldiv_op;
        mem_memread    <= keep & ex_memread;
        mem_memwrite   <= keep & ex_memwrite;
        mem_result     <= result;
        mem_store_data <= ex_rt_data;
        mem_wreg       <= ex_wreg;
        br_taken       <= keep & ex_branch & alu_zero & br_op;
        br_target      <= ex_branch_target;
      end
      if (hilo_we) begin
        hi_q <= alu_out[2*DATA_W-1:DATA_W];
        lo_q <= alu_out[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized bench for ex_mem_stage against a cycle-count reference model of the EX/MEM boundary.
module tb_ex_mem_stage;
  import mips_pkg::*;

`ifdef EXMEM_MULDIV_STALL_EN
  localparam int MUL_L = 4;
  localparam int DIV_L = 32;
`else
  localparam int MUL_L = 1;
  localparam int DIV_L = 1;
`endif

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [63:0] alu;
    logic        zero;
    logic        dbz;
    logic [31:0] rt;
    logic [4:0]  wreg;
    logic        rw, mr, mw, br, mfhi, mflo;
    logic [31:0] tgt;
  } ins_t;

  logic        clk = 1'b0, rst;
  logic [63:0] alu_out;
  logic        alu_zero, ex_valid, ex_div_by_zero, ex_regwrite, ex_memread, ex_memwrite;
  logic        ex_branch, ex_mfhi, ex_mflo, mem_stall;
  logic [3:0]  alu_op;
  logic [31:0] ex_rt_data, ex_branch_target;
  logic [4:0]  ex_wreg;
  logic        ex_stall, mem_valid, mem_regwrite, mem_memread, mem_memwrite, br_taken, flush;
  logic [31:0] mem_result, mem_store_data, br_target, hi_q, lo_q;
  logic [4:0]  mem_wreg;

  ex_mem_stage #(.DATA_W(32), .MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk(clk), .rst(rst), .alu_out(alu_out), .alu_zero(alu_zero), .alu_op(alu_op),
    .ex_valid(ex_valid), .ex_div_by_zero(ex_div_by_zero), .ex_rt_data(ex_rt_data),
    .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_mfhi(ex_mfhi), .ex_mflo(ex_mflo),
    .ex_branch_target(ex_branch_target), .mem_stall(mem_stall), .ex_stall(ex_stall),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_result(mem_result), .mem_store_data(mem_store_data),
    .mem_wreg(mem_wreg), .br_taken(br_taken), .br_target(br_target), .flush(flush),
    .hi_q(hi_q), .lo_q(lo_q)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  int stall_pct = 0;
  bit ms_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural MEM-side state plus unstalled cycles spent by the EX mult/div.
  logic        m_valid, m_rw, m_mr, m_mw, m_br, m_adv;
  logic [31:0] m_res, m_sd, m_tgt, m_hi, m_lo;
  logic [4:0]  m_wreg;
  int          spent;
  logic        e_flush, e_md, e_stall, e_mdop;
  int          e_lat;

  assign e_mdop  = (alu_op == ALU_MUL) || (alu_op == ALU_DIV);
  assign e_flush = m_br & ~mem_stall;
  assign e_md    = ex_valid & e_mdop & ~e_flush;
  assign e_lat   = (alu_op == ALU_DIV) ? DIV_L : MUL_L;
  assign e_stall = mem_stall | (e_md && (spent + 1 < e_lat));

  always @(posedge clk) begin
    if (rst) begin
      {m_valid, m_rw, m_mr, m_mw, m_br, m_adv} <= '0;
      {m_res, m_sd, m_tgt, m_hi, m_lo} <= '0;
      m_wreg <= '0;
      spent  <= 0;
    end else begin
      m_adv <= ~e_stall;
      if (!e_stall) begin
        m_valid <= ex_valid & ~e_flush;
        m_rw    <= ex_valid & ~e_flush & ex_regwrite & ~e_mdop;
        m_mr    <= ex_valid & ~e_flush & ex_memread;
        m_mw    <= ex_valid & ~e_flush & ex_memwrite;
        m_br    <= ex_valid & ~e_flush & ex_branch & alu_zero &
                   ((alu_op == ALU_BEQ) || (alu_op == ALU_BNE));
        m_res   <= ex_mfhi ? m_hi : (ex_mflo ? m_lo : alu_out[31:0]);
        m_sd    <= ex_rt_data;
        m_wreg  <= ex_wreg;
        m_tgt   <= ex_branch_target;
        if (e_md && !((alu_op == ALU_DIV) && ex_div_by_zero)) begin
          m_hi <= alu_out[63:32];
          m_lo <= alu_out[31:0];
        end
        spent <= 0;
      end else if (e_md && !mem_stall) begin
        spent <= spent + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("ex_stall", ex_stall, e_stall);
      chk("flush", flush, e_flush);
      chk("mem_valid", mem_valid, m_valid);
      chk("mem_regwrite", mem_regwrite, m_rw);
      chk("mem_memread", mem_memread, m_mr);
      chk("mem_memwrite", mem_memwrite, m_mw);
      chk("mem_result", mem_result, m_res);
      chk("mem_store_data", mem_store_data, m_sd);
      chk("mem_wreg", mem_wreg, m_wreg);
      chk("br_taken", br_taken, m_br);
      chk("br_target", br_target, m_tgt);
      chk("hi_q", hi_q, m_hi);
      chk("lo_q", lo_q, m_lo);
    end
  end

  task automatic apply(input ins_t i);
    ex_valid = i.valid; alu_op = i.op; alu_out = i.alu; alu_zero = i.zero;
    ex_div_by_zero = i.dbz; ex_rt_data = i.rt; ex_wreg = i.wreg;
    ex_regwrite = i.rw; ex_memread = i.mr; ex_memwrite = i.mw; ex_branch = i.br;
    ex_mfhi = i.mfhi; ex_mflo = i.mflo; ex_branch_target = i.tgt;
  endtask

  function automatic ins_t idle_ins();
    ins_t i;
    i = '{valid: 1'b0, op: 4'h0, alu: 64'h0, zero: 1'b0, dbz: 1'b0, rt: 32'h0, wreg: 5'h0,
          rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, mfhi: 1'b0, mflo: 1'b0, tgt: 32'h0};
    return i;
  endfunction

  function automatic ins_t mk(input logic [3:0] op, input logic [63:0] alu);
    ins_t i;
    i = idle_ins();
    i.valid = 1'b1; i.op = op; i.alu = alu; i.rw = 1'b1; i.wreg = 5'd9; i.rt = 32'hCAFE0001;
    return i;
  endfunction

  // Holds the instruction in EX until the model says it advanced.
  task automatic issue(input ins_t i, output int ncyc, output int nstall);
    bit done_i = 0;
    apply(i);
    ncyc = 0; nstall = 0;
    for (int k = 0; k < 200 && !done_i; k++) begin
      mem_stall = (ms_q.size() != 0) ? ms_q.pop_front() : ($urandom_range(99) < stall_pct);
      @(negedge clk);
      if (ex_stall === 1'b1) nstall++;
      @(posedge clk); #1;
      ncyc++;
      if (m_adv) done_i = 1;
    end
    if (!done_i) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout: got no advance expected advance within 200 cycles");
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic ins_t rnd_ins();
    ins_t i;
    int r;
    i = idle_ins();
    i.valid = ($urandom_range(9) != 0);
    r = $urandom_range(99);
    if (r < 3)       i.op = ALU_DIV;
    else if (r < 13) i.op = ALU_MUL;
    else if (r < 33) i.op = ($urandom_range(1) != 0) ? ALU_BEQ : ALU_BNE;
    else             i.op = 4'($urandom_range(5));
    i.alu  = {$urandom, $urandom};
    i.zero = $urandom_range(1);
    i.dbz  = ($urandom_range(3) == 0);
    i.rt   = $urandom;
    i.wreg = 5'($urandom_range(31));
    i.rw   = $urandom_range(1);
    i.mr   = ($urandom_range(3) == 0);
    i.mw   = ($urandom_range(3) == 0);
    i.br   = ((i.op == ALU_BEQ) || (i.op == ALU_BNE)) ? 1'b1 : ($urandom_range(9) == 0);
    r = $urandom_range(9);
    i.mfhi = (r == 0);
    i.mflo = (r == 1);
    i.tgt  = $urandom;
    return i;
  endfunction

  initial begin
    int nc, ns;
    ins_t i;
    // Reset with every input busy and nonzero.
    i = mk(ALU_MUL, 64'hFFFF_FFFF_FFFF_FFFF);
    i.mr = 1; i.mw = 1; i.br = 1; i.zero = 1; i.tgt = 32'hFFFF_FFFF;
    apply(i); mem_stall = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; mem_stall = 1'b0; apply(idle_ins());
    chk_en = 1;
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_ctrl", {mem_regwrite, mem_memread, mem_memwrite, br_taken, flush, ex_stall}, 0);
    chk("rst_mem_data", {mem_result, mem_store_data, br_target, 27'h0, mem_wreg}, 0);
    chk("rst_hilo", {hi_q, lo_q}, 0);

    // mult: LAT-1 stall cycles, HI/LO written, no register write into MEM.
    issue(mk(ALU_MUL, 64'h0000_0001_FFFF_FFFE), nc, ns);
    chk("mul_stall_cycles", ns, MUL_L - 1);
    chk("mul_hi", hi_q, 32'h1);
    chk("mul_lo", lo_q, 32'hFFFF_FFFE);
    chk("mul_regwrite", mem_regwrite, 0);
    chk("mul_valid", mem_valid, 1);

    // div 17/3 then div by zero.
    issue(mk(ALU_DIV, {32'd2, 32'd5}), nc, ns);
    chk("div_stall_cycles", ns, DIV_L - 1);
    chk("div_hilo", {hi_q, lo_q}, {32'd2, 32'd5});
    i = mk(ALU_DIV, 64'h0BAD_0BAD_DEAD_BEEF); i.dbz = 1;
    issue(i, nc, ns);
    chk("div0_hilo", {hi_q, lo_q}, {32'd2, 32'd5});

    // mfhi right after the write sees the new HI.
    i = mk(ALU_ADD, 64'h0); i.mfhi = 1;
    issue(i, nc, ns);
    chk("mfhi_result", mem_result, 32'd2);

    // Taken beq: one flush pulse, next instruction becomes a bubble.
    i = mk(ALU_BEQ, 64'h0); i.br = 1; i.zero = 1; i.rw = 0; i.tgt = 32'h0040_0020;
    issue(i, nc, ns);
    chk("beq_taken", br_taken, 1);
    chk("beq_target", br_target, 32'h0040_0020);
    chk("beq_flush", flush, 1);
    issue(mk(ALU_ADD, 64'h55), nc, ns);
    chk("bubble_valid", mem_valid, 0);
    chk("bubble_regwrite", mem_regwrite, 0);
    chk("br_one_pulse", {br_taken, flush}, 0);

    // mult with 2 cycles of mem_stall while busy.
    ms_q.push_back(0); ms_q.push_back(1); ms_q.push_back(1);
    issue(mk(ALU_MUL, 64'h1234_5678_9ABC_DEF0), nc, ns);
    ms_q.delete(); mem_stall = 1'b0;
    chk("mul_ms_cycles", nc, (MUL_L > 1) ? MUL_L + 2 : 1);
    chk("mul_ms_hilo", {hi_q, lo_q}, 64'h1234_5678_9ABC_DEF0);

    // Reset in the middle of a mult.
    apply(mk(ALU_MUL, 64'h7777_7777_8888_8888));
    step(); step();
    rst = 1'b1; apply(idle_ins());
    step();
    rst = 1'b0;
    #1;
    chk("midrst_hilo", {hi_q, lo_q}, 0);
    chk("midrst_stall", ex_stall, 0);

    // Randomized traffic with background mem_stall.
    stall_pct = 20;
    for (int n = 0; n < 1500; n++) issue(rnd_ins(), nc, ns);
    stall_pct = 0;
    apply(idle_ins()); mem_stall = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
